// File: rtl/clkdiv_mc.sv
// Multi-channel programmable clock divider: each channel divides clki by divs+1 and
// produces a near-50% registered clock plus an end-of-period pulse.
module clkdiv_mc #(
    parameter int NCH     = 4,
    parameter int DW      = 8,
    parameter int DIV_RST = 0
) (
    input  logic                clki,
    input  logic                rst,
    input  logic [NCH*DW-1:0]   divs,
    input  logic [NCH-1:0]      ch_en,
    input  logic                sync_req,
    output logic [NCH-1:0]      clko,
    output logic [NCH-1:0]      plso
);

    localparam logic [DW-1:0] SS_RST = DW'(DIV_RST);
    localparam logic [DW:0]   ONE_X  = (DW+1)'(1);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic          act_reg;
            logic [DW-1:0] ss_reg;
            logic [DW-1:0] ss_next;
            logic [DW-1:0] cnt_reg;
            logic [DW-1:0] cnt_next;
            logic          clko_reg;
            logic          clko_next;
            logic          plso_reg;
            logic          plso_next;
            logic [DW-1:0] div_i;
            logic [DW:0]   half_next;
            logic          restart;

            assign div_i = divs[gi*DW +: DW];

            // A fresh period starts on activation, realign request or natural boundary;
            // the shadow divisor is only reloaded at those points.
            assign restart = !act_reg || sync_req || (cnt_reg == ss_reg);

            always_comb begin
                ss_next   = ss_reg;
                cnt_next  = cnt_reg;
                half_next = '0;
                clko_next = 1'b0;
                plso_next = 1'b0;
                if (!ch_en[gi] || restart) begin
                    cnt_next = '0;
                    ss_next  = div_i;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
                // Outputs decode next-state values so they line up with cnt_reg.
                half_next = {1'b0, (ss_next >> 1)} + ONE_X;
                clko_next = ch_en[gi] && ({1'b0, cnt_next} < half_next);
                plso_next = ch_en[gi] && (cnt_next == ss_next);
            end

            always_ff @(posedge clki) begin
                if (rst) begin
                    act_reg  <= 1'b0;
                    ss_reg   <= SS_RST;
                    cnt_reg  <= '0;
                    clko_reg <= 1'b0;
                    plso_reg <= 1'b0;
                end else begin
                    act_reg  <= ch_en[gi];
                    ss_reg   <= ss_next;
                    cnt_reg  <= cnt_next;
                    clko_reg <= clko_next;
                    plso_reg <= plso_next;
                end
            end

            assign clko[gi] = clko_reg;
            assign plso[gi] = plso_reg;
        end
    endgenerate

endmodule

// File: doc/clkdiv_mc.md
Name: clkdiv_mc

Overview:
- Multi-channel, parametrised synchronous clock divider. Next generation of the single-channel divider.
- Each of NCH channels divides clki by a programmable ratio N = divs+1.
- Each channel produces a glitch-free registered divided clock, near-50% duty for odd and even N, plus a one-cycle end-of-period pulse.
- Adds per-channel enable, boundary-safe ratio update and a global phase-realign request.
- Sits in the clock/reset block and feeds peripheral clock enables and low-speed functional clocks.

Parameters:
- NCH, 4, number of independent divider channels (1..16).
- DW, 8, divisor field width per channel.
- DIV_RST, 0, divisor value loaded into every channel's shadow register on reset.

Ports:
- clki  input  1  source clock; all flops are on its rising edge.
- rst  input  1  synchronous reset, active-high.
- divs  input  NCH*DW  per-channel divisor; channel i uses divs[i*DW +: DW]; ratio N = divs+1.
- ch_en  input  NCH  per-channel enable, level-sensitive.
- sync_req  input  1  single-cycle request to realign the phase of all active channels.
- clko  output  NCH  registered divided clock per channel.
- plso  output  NCH  registered pulse, high on the last clki cycle of each period.

Behaviour:
- Per-channel state: act (enable flop), ss (DW-bit shadow divisor), cnt (DW-bit counter), clko flop, plso flop. All outputs come directly from flops; there is no combinational path from any input to any output.
- Reset (rst=1 at an edge): act=0, ss=DIV_RST, cnt=0, clko=0, plso=0 on all channels. rst overrides every other input. Reset mid-period abandons the period immediately.
- Define H = (ss>>1)+1 = ceil(N/2). clko is 1 in cycles where act=1 and cnt<H, otherwise 0.
- Resulting duty: N=1 gives clko constant 1; N=2 gives 1 high/1 low; N=3 gives 2 high/1 low; N=4 gives 2 high/2 low.
- plso is 1 in cycles where act=1 and cnt==ss; otherwise 0. For N=1, plso is constant 1 while active.
- Implement clko and plso from next-state values so they align with cnt in the same cycle.
- act <= ch_en each edge.
- Inactive channel (next act=0): cnt <= 0, ss <= divs(i) every cycle, clko=0, plso=0.
- Activation: ch_en sampled 1 at edge k while act=0. After edge k: act=1, cnt=0, ss=divs(i) as sampled at edge k, clko=1. This is the first cycle of a full period; latency from ch_en to first clko high is one edge.
- Counting while active: cnt <= (cnt==ss) ? 0 : cnt+1. Arithmetic is DW-bit and wraps only through the cnt==ss compare; a counter beyond ss cannot occur.
- Divisor update: ss <= divs(i) only at the period boundary (edge where cnt==ss), so the new ratio applies from the next period. Changes of divs mid-period have no effect on the current period; no runt or stretched pulse.
- Deactivation: ch_en sampled 0 stops the channel at the next edge regardless of cnt (clko=0, plso=0). Software must gate downstream use accordingly.
- sync_req=1 at an edge: every channel whose next act=1 gets cnt <= 0 and ss <= divs(i), starting a fresh period.
  - sync_req coincident with a boundary gives the same result.
  - sync_req coincident with activation gives the same result.
  - sync_req has no effect on inactive channels.
- Channels are fully independent except for the shared sync_req and rst.

Test Plan:
- Reset and activate: rst 3 cycles, divs ch0=3, ch_en=0001 → clko/plso all 0 during reset. One edge after ch_en, clko0 pattern is 1100 repeating and plso0 is 0001 repeating; ch1..3 stay 0.
- Odd/unity ratios: ch0 divs=2, ch1 divs=0, ch2 divs=4 → clko0 110, plso0 001; clko1 and plso1 constant 1; clko2 11100, plso2 00001.
- Boundary-safe update: ch0 divs=3 running; change divs to 1 at cnt=1 → current period completes as 1100 (4 cycles), then 10 repeating. No 3-cycle or other partial period.
- Realign: ch0 divs=3, ch1 divs=5 running out of phase; pulse sync_req → after that edge both at cnt=0 with clko=1. plso0 next high 3 cycles later, plso1 5 cycles later.
- Enable/disable mid-period: ch2 divs=7; drop ch_en at cnt=5 → clko2=0 and plso2=0 from next edge. Re-assert → fresh 8-cycle period starting 11110000.
- Reset mid-operation: all channels running; assert rst for 1 cycle at arbitrary cnt → all outputs 0 next edge and ss=DIV_RST. With ch_en held 1 through reset, channels restart at cnt=0 one edge after rst falls.
